// File: rtl/qracc_wrapper.sv
// qracc_wrapper
// Digital controller for a charge-domain compute-in-memory macro.
//   - SRAM side: single-word read/write over a valid/ready handshake.
//     Drives WL/PCH/WRITE/CSEL/WR_DATA/SAEN and captures SA_OUT.
//   - MAC side: while mac_en_i is high, drives the per-row switch matrix
//     from bipolar row inputs (data_p_i/data_n_i), and turns each column's
//     thermometer ADC code into a signed, optionally right-shifted result.
// Ports:
//   clk, nrst                 clock and synchronous active-high reset
//   n_input_bits_cfg          reserved (registered only)
//   n_adc_bits_cfg            effective ADC bits for result scaling
//   binary_cfg                1 = binary, 0 = ternary/bipolar (drives NF)
//   VDR/VSS/VRST_SEL(B)       switch-matrix selects and complements
//   SA_OUT, WL, PCH, WR_DATA, WRITE, CSEL, SAEN   SRAM array interface
//   ADC_OUT                   per-column thermometer codes (column k = slice k)
//   NF, M2A, R2A (+B)         ADC control and complements
//   adc_out_o                 signed per-column results (column k = slice k)
//   mac_en_i, data_p_i, data_n_i   MAC mode request and row inputs
//   rq_*, rd_*, wr_data_i, addr_i  SRAM request interface
module qracc_wrapper #(
  parameter int numRows    = 128,
  parameter int numCols    = 8,
  parameter int numAdcBits = 4,
  parameter int numCfgBits = 8
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [numCfgBits-1:0]            n_input_bits_cfg,
  input  logic [numCfgBits-1:0]            n_adc_bits_cfg,
  input  logic                             binary_cfg,
  output logic [numRows-1:0]               VDR_SEL,
  output logic [numRows-1:0]               VDR_SELB,
  output logic [numRows-1:0]               VSS_SEL,
  output logic [numRows-1:0]               VSS_SELB,
  output logic [numRows-1:0]               VRST_SEL,
  output logic [numRows-1:0]               VRST_SELB,
  input  logic [numCols-1:0]               SA_OUT,
  output logic [numRows-1:0]               WL,
  output logic                             PCH,
  output logic [numCols-1:0]               WR_DATA,
  output logic                             WRITE,
  output logic [numCols-1:0]               CSEL,
  output logic                             SAEN,
  input  logic [numCols*(2**numAdcBits)-1:0] ADC_OUT,
  output logic                             NF,
  output logic                             NFB,
  output logic                             M2A,
  output logic                             M2AB,
  output logic                             R2A,
  output logic                             R2AB,
  output logic [numCols*numAdcBits-1:0]    adc_out_o,
  input  logic                             mac_en_i,
  input  logic [numRows-1:0]               data_p_i,
  input  logic [numRows-1:0]               data_n_i,
  input  logic                             rq_wr_i,
  input  logic                             rq_valid_i,
  output logic                             rq_ready_o,
  output logic                             rd_valid_o,
  output logic [numCols-1:0]               rd_data_o,
  input  logic [numCols-1:0]               wr_data_i,
  input  logic [$clog2(numRows)-1:0]       addr_i
);

  localparam int ADDR_W = $clog2(numRows);
  localparam int THERM  = 2**numAdcBits;
  localparam logic [numRows-1:0]    ROW_ONE      = {{(numRows-1){1'b0}}, 1'b1};
  localparam logic [numAdcBits-1:0] ADC_HALF     = numAdcBits'(2**(numAdcBits-1));
  localparam logic [numCfgBits-1:0] ADC_BITS_CFG = numCfgBits'(numAdcBits);

  typedef enum logic [2:0] {
    IDLE, WR, RD_PCH, RD_WL, RD_SENSE, RD_OUT, MAC_RST, MAC_EVAL
  } state_t;

  state_t                        state_reg;
  logic [ADDR_W-1:0]             addr_reg;
  logic [numCfgBits-1:0]         n_input_bits_unused_reg;
  logic [numRows-1:0]            wl_reg;
  logic [numRows-1:0]            vdr_reg;
  logic [numRows-1:0]            vss_reg;
  logic [numRows-1:0]            vrst_reg;
  logic [numCols-1:0]            wr_data_reg;
  logic [numCols-1:0]            csel_reg;
  logic [numCols-1:0]            rd_data_reg;
  logic [numCols*numAdcBits-1:0] adc_out_reg;
  logic                          write_reg;
  logic                          pch_reg;
  logic                          saen_reg;
  logic                          rd_valid_reg;
  logic                          m2a_reg;
  logic                          r2a_reg;

  // Ready is combinational on mac_en_i so a pending MAC request blocks new
  // SRAM requests in the very cycle it appears.
  assign rq_ready_o = (state_reg == IDLE) && !mac_en_i && !nrst;

  // Row selects for an evaluation cycle: exactly one of VDR/VSS/VRST per row.
  logic [numRows-1:0] vdr_next;
  logic [numRows-1:0] vss_next;
  assign vdr_next = data_p_i & ~data_n_i;
  assign vss_next = data_n_i & ~data_p_i;

  // ---------------------------------------------------------------------
  // ADC decode: popcount of thermometer bits [THERM-1:1], re-centred to a
  // signed value, then arithmetic-shifted down for reduced resolution.
  // ---------------------------------------------------------------------
  logic [numCfgBits-1:0]         adc_shamt;
  logic [numCols*numAdcBits-1:0] adc_dec;
  logic [numCols-1:0]            adc_bit0_unused;

  always_comb begin
    adc_shamt = '0;
    if (n_adc_bits_cfg != '0 && n_adc_bits_cfg < ADC_BITS_CFG)
      adc_shamt = ADC_BITS_CFG - n_adc_bits_cfg;
  end

  generate
    for (genvar gi = 0; gi < numCols; gi++) begin : g_col
      logic [numAdcBits-1:0]        cnt;
      logic signed [numAdcBits-1:0] centred;

      // Sum of THERM-1 single bits always fits in numAdcBits bits.
      always_comb begin
        cnt = '0;
        for (int j = 1; j < THERM; j++)
          cnt = cnt + numAdcBits'(ADC_OUT[gi*THERM + j]);
      end

      assign centred = cnt - ADC_HALF;
      assign adc_dec[gi*numAdcBits +: numAdcBits] = centred >>> adc_shamt;
      // Bit 0 of each thermometer code carries no information.
      assign adc_bit0_unused[gi] = ADC_OUT[gi*THERM];
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{adc_bit0_unused, n_input_bits_unused_reg};

  // ---------------------------------------------------------------------
  // Controller FSM. Outputs are registered alongside the state so each
  // output value is valid during the cycle of the state that owns it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_reg               <= IDLE;
      addr_reg                <= '0;
      n_input_bits_unused_reg <= '0;
      wl_reg                  <= '0;
      vdr_reg                 <= '0;
      vss_reg                 <= '0;
      vrst_reg                <= '1;
      wr_data_reg             <= '0;
      csel_reg                <= '0;
      rd_data_reg             <= '0;
      adc_out_reg             <= '0;
      write_reg               <= 1'b0;
      pch_reg                 <= 1'b0;
      saen_reg                <= 1'b0;
      rd_valid_reg            <= 1'b0;
      m2a_reg                 <= 1'b0;
      r2a_reg                 <= 1'b0;
    end else begin
      n_input_bits_unused_reg <= n_input_bits_cfg;

      // Idle values; each state below overrides what it drives.
      wl_reg       <= '0;
      vdr_reg      <= '0;
      vss_reg      <= '0;
      vrst_reg     <= '1;
      wr_data_reg  <= '0;
      csel_reg     <= '0;
      write_reg    <= 1'b0;
      pch_reg      <= 1'b0;
      saen_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      m2a_reg      <= 1'b0;
      r2a_reg      <= 1'b0;

      if (state_reg == MAC_EVAL)
        adc_out_reg <= adc_dec;

      case (state_reg)
        IDLE: begin
          if (mac_en_i) begin
            state_reg <= MAC_RST;
            wl_reg    <= '1;
            r2a_reg   <= 1'b1;
          end else if (rq_valid_i) begin
            addr_reg <= addr_i;
            if (rq_wr_i) begin
              state_reg   <= WR;
              wl_reg      <= ROW_ONE << addr_i;
              write_reg   <= 1'b1;
              csel_reg    <= '1;
              wr_data_reg <= wr_data_i;
            end else begin
              state_reg <= RD_PCH;
              pch_reg   <= 1'b1;
            end
          end
        end
        WR: state_reg <= IDLE;
        RD_PCH: begin
          state_reg <= RD_WL;
          wl_reg    <= ROW_ONE << addr_reg;
        end
        RD_WL: begin
          state_reg <= RD_SENSE;
          wl_reg    <= ROW_ONE << addr_reg;
          saen_reg  <= 1'b1;
        end
        RD_SENSE: begin
          state_reg    <= RD_OUT;
          rd_data_reg  <= SA_OUT;
          rd_valid_reg <= 1'b1;
        end
        RD_OUT: state_reg <= IDLE;
        MAC_RST, MAC_EVAL: begin
          if (mac_en_i) begin
            state_reg <= MAC_EVAL;
            wl_reg    <= '1;
            m2a_reg   <= 1'b1;
            vdr_reg   <= vdr_next;
            vss_reg   <= vss_next;
            vrst_reg  <= ~(vdr_next | vss_next);
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign WL        = wl_reg;
  assign PCH       = pch_reg;
  assign WR_DATA   = wr_data_reg;
  assign WRITE     = write_reg;
  assign CSEL      = csel_reg;
  assign SAEN      = saen_reg;
  assign VDR_SEL   = vdr_reg;
  assign VDR_SELB  = ~vdr_reg;
  assign VSS_SEL   = vss_reg;
  assign VSS_SELB  = ~vss_reg;
  assign VRST_SEL  = vrst_reg;
  assign VRST_SELB = ~vrst_reg;
  assign NF        = ~binary_cfg;
  assign NFB       = binary_cfg;
  assign M2A       = m2a_reg;
  assign M2AB      = ~m2a_reg;
  assign R2A       = r2a_reg;
  assign R2AB      = ~r2a_reg;
  assign rd_valid_o = rd_valid_reg;
  assign rd_data_o  = rd_data_reg;
  assign adc_out_o  = adc_out_reg;

endmodule

// File: tb/tb_qracc_wrapper.sv
module tb_qracc_wrapper;

  localparam int NR = 128;
  localparam int NC = 8;
  localparam int NA = 4;
  localparam int NCFG = 8;
  localparam int AW = 7;

  logic              clk = 1'b0;
  logic              nrst;
  logic [NCFG-1:0]   n_input_bits_cfg;
  logic [NCFG-1:0]   n_adc_bits_cfg;
  logic              binary_cfg;
  logic [NR-1:0]     VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB;
  logic [NC-1:0]     SA_OUT;
  logic [NR-1:0]     WL;
  logic              PCH;
  logic [NC-1:0]     WR_DATA;
  logic              WRITE;
  logic [NC-1:0]     CSEL;
  logic              SAEN;
  logic [NC*16-1:0]  ADC_OUT;
  logic              NF, NFB, M2A, M2AB, R2A, R2AB;
  logic [NC*NA-1:0]  adc_out_o;
  logic              mac_en_i;
  logic [NR-1:0]     data_p_i, data_n_i;
  logic              rq_wr_i, rq_valid_i, rq_ready_o, rd_valid_o;
  logic [NC-1:0]     rd_data_o, wr_data_i;
  logic [AW-1:0]     addr_i;

  logic [NC-1:0]     sa_val;
  // Sense amps only present data while enabled, so a mistimed capture is visible.
  assign SA_OUT = SAEN ? sa_val : '0;

  always #5 clk = ~clk;

  qracc_wrapper #(.numRows(NR), .numCols(NC), .numAdcBits(NA), .numCfgBits(NCFG)) dut (
    .clk(clk), .nrst(nrst), .n_input_bits_cfg(n_input_bits_cfg),
    .n_adc_bits_cfg(n_adc_bits_cfg), .binary_cfg(binary_cfg),
    .VDR_SEL(VDR_SEL), .VDR_SELB(VDR_SELB), .VSS_SEL(VSS_SEL), .VSS_SELB(VSS_SELB),
    .VRST_SEL(VRST_SEL), .VRST_SELB(VRST_SELB), .SA_OUT(SA_OUT), .WL(WL), .PCH(PCH),
    .WR_DATA(WR_DATA), .WRITE(WRITE), .CSEL(CSEL), .SAEN(SAEN), .ADC_OUT(ADC_OUT),
    .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB), .R2A(R2A), .R2AB(R2AB),
    .adc_out_o(adc_out_o), .mac_en_i(mac_en_i), .data_p_i(data_p_i), .data_n_i(data_n_i),
    .rq_wr_i(rq_wr_i), .rq_valid_i(rq_valid_i), .rq_ready_o(rq_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .wr_data_i(wr_data_i), .addr_i(addr_i)
  );

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [NC-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_wr_pulses = 0;
  logic [NR-1:0] row_one = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns just after the accepting edge.
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [NC-1:0] d, input bit hold);
    int waited;
    exp_t e;
    e.is_wr = wr; e.addr = a; e.data = wr ? d : sa_val;
    exp_q.push_back(e);
    rq_valid_i = 1'b1; rq_wr_i = wr; addr_i = a; wr_data_i = d;
    waited = 0;
    while (!rq_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    check("req_accept_timeout", 128'(waited < 20), 128'(1));
    tick();
    if (!hold) rq_valid_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or read result.
  always @(negedge clk) begin
    if (!nrst) begin
      if (WRITE) begin
        n_wr_pulses++;
        check("sb_write_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("sb_write_kind", 128'(mon_e.is_wr), 128'(1));
          check("sb_write_WL", WL, row_one << mon_e.addr);
          check("sb_write_WR_DATA", WR_DATA, mon_e.data);
          check("sb_write_CSEL", CSEL, 8'hFF);
          check("sb_write_ready_low", rq_ready_o, 0);
          $display("[TB] write addr=%0d data=%02h", mon_e.addr, WR_DATA);
        end
      end
      if (rd_valid_o) begin
        check("sb_read_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("sb_read_kind", 128'(mon_e.is_wr), 128'(0));
          check("sb_read_data", rd_data_o, mon_e.data);
          $display("[TB] read addr=%0d data=%02h", mon_e.addr, rd_data_o);
        end
      end
    end
  end

  initial begin
    nrst = 1'b1; n_input_bits_cfg = 8'h3; n_adc_bits_cfg = 8'd4; binary_cfg = 1'b0;
    ADC_OUT = '0; mac_en_i = 1'b0; data_p_i = '0; data_n_i = '0;
    rq_wr_i = 1'b0; rq_valid_i = 1'b0; wr_data_i = '0; addr_i = '0; sa_val = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", rq_ready_o, 0);
    check("rst_WL", WL, 0);
    check("rst_VRST", VRST_SEL, {NR{1'b1}});
    check("rst_VDR", VDR_SEL, 0);
    check("rst_VSS", VSS_SEL, 0);
    check("rst_ctrl", {WRITE, PCH, SAEN, rd_valid_o, M2A, R2A}, 0);
    check("rst_data", {WR_DATA, CSEL, rd_data_o, adc_out_o}, 0);
    check("rst_NF", {NF, NFB}, 2'b10);
    check("rst_VRSTB", VRST_SELB, 0);
    nrst = 1'b0;
    tick();
    check("idle_ready", rq_ready_o, 1);
    binary_cfg = 1'b1;
    #1;
    check("binary_NF", {NF, NFB}, 2'b01);
    binary_cfg = 1'b0;

    // Single write
    do_req(1'b1, 7'd5, 8'hA5, 1'b0);
    check("wr_WL", WL, row_one << 5);
    check("wr_WRITE", WRITE, 1);
    check("wr_DATA", WR_DATA, 8'hA5);
    check("wr_CSEL", CSEL, 8'hFF);
    check("wr_ready_low", rq_ready_o, 0);
    tick();
    check("wr_done_WRITE", WRITE, 0);
    check("wr_done_WL", WL, 0);
    check("wr_done_ready", rq_ready_o, 1);

    // Single read
    sa_val = 8'hA5;
    do_req(1'b0, 7'd5, 8'h00, 1'b0);
    check("rd1_pch", {PCH, SAEN, rd_valid_o}, 3'b100);
    check("rd1_WL", WL, 0);
    tick();
    check("rd2_pch", {PCH, SAEN, rd_valid_o}, 3'b000);
    check("rd2_WL", WL, row_one << 5);
    tick();
    check("rd3_saen", {PCH, SAEN, rd_valid_o}, 3'b010);
    check("rd3_WL", WL, row_one << 5);
    tick();
    check("rd4_valid", {PCH, SAEN, rd_valid_o}, 3'b001);
    check("rd4_data", rd_data_o, 8'hA5);
    check("rd4_WL", WL, 0);
    tick();
    check("rd5_valid_low", rd_valid_o, 0);
    check("rd5_data_held", rd_data_o, 8'hA5);

    // Back-to-back writes to every row with valid held high
    for (int i = 0; i < NR; i++)
      do_req(1'b1, AW'(i), NC'(i) ^ 8'h3C, 1'b1);
    rq_valid_i = 1'b0;
    repeat (2) tick();
    check("b2b_pulses", n_wr_pulses, 129);
    check("b2b_queue_empty", exp_q.size(), 0);

    // MAC mode: rows 0..3 = (1,0) (0,1) (0,0) (1,1)
    data_p_i = 128'h9; data_n_i = 128'hA;
    ADC_OUT = 128'h0000_0000_0000_0000_0000_003F_0001_FFFF;
    n_adc_bits_cfg = 8'd4;
    mac_en_i = 1'b1;
    #1;
    check("mac_req_ready_low", rq_ready_o, 0);
    tick();
    check("macrst_R2A_M2A", {R2A, R2AB, M2A, M2AB}, 4'b1001);
    check("macrst_WL", WL, {NR{1'b1}});
    check("macrst_VRST", VRST_SEL, {NR{1'b1}});
    tick();
    check("maceval_R2A_M2A", {R2A, R2AB, M2A, M2AB}, 4'b0110);
    check("maceval_WL", WL, {NR{1'b1}});
    check("maceval_VDR", VDR_SEL, 128'h1);
    check("maceval_VSS", VSS_SEL, 128'h2);
    check("maceval_VRST", VRST_SEL, ~128'h3);
    check("maceval_VDRB", VDR_SELB, ~128'h1);
    check("maceval_VSSB", VSS_SELB, ~128'h2);
    check("maceval_VRSTB", VRST_SELB, 128'h3);
    check("maceval_adc_latency", adc_out_o, 0);
    tick();
    check("adc_n4", adc_out_o, 32'h88888D87);
    n_adc_bits_cfg = 8'd2;
    tick();
    check("adc_n2", adc_out_o, 32'hEEEEEFE1);
    n_adc_bits_cfg = 8'd3;
    tick();
    check("adc_n3", adc_out_o, 32'hCCCCCEC3);
    n_adc_bits_cfg = 8'd0;
    data_p_i = '0; data_n_i = '1;
    tick();
    check("adc_n0", adc_out_o, 32'h88888D87);
    check("mac_all_VSS", {VSS_SEL, VDR_SEL}, {{NR{1'b1}}, {NR{1'b0}}});
    check("mac_all_VSS_VRST", VRST_SEL, 0);
    mac_en_i = 1'b0;
    tick();
    check("macexit_ready", rq_ready_o, 1);
    check("macexit_VRST", VRST_SEL, {NR{1'b1}});
    check("macexit_VSS", VSS_SEL, 0);
    check("macexit_WL_M2A", {WL, M2A}, 0);
    ADC_OUT = '0;
    tick();
    check("adc_held", adc_out_o, 32'h88888D87);
    data_n_i = '0;

    // MAC request during a read: read finishes first
    sa_val = 8'h3C;
    do_req(1'b0, 7'd9, 8'h00, 1'b0);
    mac_en_i = 1'b1;
    tick();
    check("macrd_WL", WL, row_one << 9);
    tick();
    tick();
    check("macrd_valid", rd_valid_o, 1);
    check("macrd_data", rd_data_o, 8'h3C);
    tick();
    check("macrd_idle_ready", rq_ready_o, 0);
    check("macrd_idle_R2A", {R2A, rd_valid_o}, 0);
    tick();
    check("macrd_macrst", R2A, 1);
    mac_en_i = 1'b0;
    tick();
    check("macrd_exit_ready", rq_ready_o, 1);
    check("macrd_exit_VRST", VRST_SEL, {NR{1'b1}});

    // Reset in the middle of a read aborts it with no rd_valid pulse
    sa_val = 8'h77;
    do_req(1'b0, 7'd3, 8'h00, 1'b0);
    tick();
    nrst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_ready", rq_ready_o, 0);
    check("midrst_ctrl", {WL, SAEN, rd_valid_o}, 0);
    nrst = 1'b0;
    repeat (4) tick();
    check("midrst_rd_data", rd_data_o, 0);
    check("midrst_ready_after", rq_ready_o, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qracc_wrapper.md
Name: qracc_wrapper

Overview:
- Digital controller for the charge-domain compute-in-memory macro (numRows x numCols SRAM, per-row switch matrix, per-column thermometer ADC).
- Serves single-word SRAM read/write requests over a valid/ready handshake.
- In MAC mode, drives the switch matrix from bipolar row inputs and converts ADC thermometer codes into signed per-column results.
- Sits between the digital system and the analog macro.

Parameters:
- numRows, 128, SRAM rows / MAC input lanes
- numCols, 8, SRAM columns / MAC outputs
- numAdcBits, 4, ADC resolution; each column has a 2**numAdcBits thermometer bus
- numCfgBits, 8, width of configuration inputs

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  synchronous active-high reset (1 = reset)
- n_input_bits_cfg  in  numCfgBits  reserved; registered, no functional effect
- n_adc_bits_cfg  in  numCfgBits  effective ADC bits
- binary_cfg  in  1  1 = binary mode, 0 = ternary/bipolar mode
- VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB  out  numRows each  switch-matrix selects and complements
- SA_OUT  in  numCols  sense-amp outputs
- WL  out  numRows  word lines
- PCH  out  1  bitline precharge
- WR_DATA  out  numCols  write data
- WRITE  out  1  write enable
- CSEL  out  numCols  column select
- SAEN  out  1  sense-amp enable
- ADC_OUT  in  numCols*2**numAdcBits  per-column thermometer codes; column k occupies slice k
- NF, NFB, M2A, M2AB, R2A, R2AB  out  1 each  ADC control signals and complements
- adc_out_o  out  numCols*numAdcBits  signed result per column; column k occupies slice k
- mac_en_i  in  1  MAC mode request
- data_p_i, data_n_i  in  numRows  bipolar input per row (+1 / -1 flags)
- rq_wr_i  in  1  1 = write, 0 = read
- rq_valid_i  in  1  request valid
- rq_ready_o  out  1  ready to accept a request
- rd_valid_o  out  1  read data valid pulse
- rd_data_o  out  numCols  read data
- wr_data_i  in  numCols  write data
- addr_i  in  clog2(numRows)  row address

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - WL, WR_DATA, CSEL, rd_data_o, adc_out_o = 0.
  - WRITE, PCH, SAEN, rd_valid_o, M2A, R2A = 0.
  - rq_ready_o = 0 during reset.
  - VRST_SEL = all 1, VDR_SEL = VSS_SEL = 0.
- Complement outputs are always the bitwise inverse of their true signal (e.g. VDR_SELB = ~VDR_SEL, M2AB = ~M2A).
- FSM states: IDLE, WR, RD_PCH, RD_WL, RD_SENSE, RD_OUT, MAC_RST, MAC_EVAL.
- Handshake:
  - rq_ready_o = 1 only in IDLE with mac_en_i = 0.
  - A request is accepted on a rising edge where rq_valid_i && rq_ready_o; addr_i, wr_data_i and rq_wr_i are latched on that edge.
- Write path:
  - IDLE -> WR for exactly 1 cycle: WL[addr] = 1, WRITE = 1, CSEL = all 1, WR_DATA = latched data.
  - Then back to IDLE.
- Read path:
  - RD_PCH (PCH = 1) -> RD_WL (WL[addr] = 1) -> RD_SENSE (WL[addr] = 1, SAEN = 1) -> RD_OUT -> IDLE, one cycle each.
  - rd_data_o captures SA_OUT at the end of RD_SENSE.
  - rd_valid_o = 1 for exactly the RD_OUT cycle, i.e. the 4th cycle after the accepting edge.
  - rd_data_o holds its value until the next read completes.
- Request priority: if mac_en_i rises during an SRAM operation, the operation completes first; MAC mode is entered from IDLE. SRAM requests are not accepted in MAC mode.
- MAC mode, entry: IDLE with mac_en_i = 1 -> MAC_RST for 1 cycle with R2A = 1, M2A = 0, WL = all 1, VRST_SEL = all 1.
- MAC mode, MAC_EVAL (every cycle while mac_en_i = 1):
  - WL = all 1, M2A = 1, R2A = 0.
  - Per row: data_p = 1 and data_n = 0 -> VDR_SEL = 1; data_n = 1 and data_p = 0 -> VSS_SEL = 1; any other combination (including both set) -> VRST_SEL = 1.
  - Exactly one of the three selects is high per row.
- MAC mode, exit: mac_en_i = 0 in a MAC state -> IDLE on the next edge. Outside MAC mode the switch matrix returns to the all-VRST state.
- NF = ~binary_cfg, in all states.
- ADC decode:
  - Column value = popcount of bits [2**N-1:1] of the column's slice; bit 0 is ignored. Range is 0..2**N-1.
  - Result = value - 2**(N-1), as an N-bit two's-complement number (-8..7 for N = 4).
  - If 1 <= n_adc_bits_cfg < N, the result is arithmetic-right-shifted by N - n_adc_bits_cfg.
  - adc_out_o is registered on every MAC_EVAL edge: 1-cycle latency, held otherwise.
- Reset mid-operation: aborts the operation on the next edge; no rd_valid_o pulse is produced.

Test Plan:
- Reset, then write addr 5 data 0xA5 -> WL[5] and WRITE high for exactly 1 cycle with WR_DATA = 0xA5, CSEL = 0xFF; rq_ready_o low in that cycle and high after.
- Read addr 5 with SA_OUT driven to 0xA5 during RD_SENSE -> PCH, WL and SAEN sequence as specified; rd_valid_o pulses 4 cycles after acceptance with rd_data_o = 0xA5.
- Back-to-back writes to all 128 rows with rq_valid_i held high -> each accepted once; a one-hot WL pulse per address; no missed or duplicated addresses.
- MAC mode, rows 0/1/2 with (p,n) = (1,0)/(0,1)/(0,0) -> rows select VDR/VSS/VRST respectively, SELB lines are complements, WL = all 1, M2A = 1 after one MAC_RST cycle with R2A = 1.
- ADC_OUT column 0 slice = 0xFFFF, column 1 slice = 0x0001 -> adc_out_o col0 = +7, col1 = -8; with n_adc_bits_cfg = 2 -> col0 = +1, col1 = -2.
- mac_en_i asserted during a read -> read completes with rd_valid_o, then MAC_RST; mac_en_i deasserted -> IDLE, all VRST, rq_ready_o = 1.
